// File: rtl/approx_adder_pipe_et_pkg.sv
// Shared definitions for the pipelined approximate adder.
//   mode_t   : per-beat arithmetic mode carried alongside the operands
//   ABS_W    : working width of abs_diff (operands are zero-extended to it)
//   abs_diff : |x - y| for unsigned operands
package approx_adder_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'd0,
    MODE_LOA   = 2'd1,  // lower-part OR adder
    MODE_TRUNC = 2'd2,  // low bits forced to zero, no carry-in
    MODE_RSVD  = 2'd3   // behaves as exact
  } mode_t;

  localparam int ABS_W = 64;

  function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] x,
                                                input logic [ABS_W-1:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/approx_adder_pipe_et_if.sv
// Operand/result stream bundle for approx_adder_pipe_et.
//   in_valid/in_ready/in_a/in_b/in_mode : operand beat (producer -> adder)
//   out_valid/out_ready/out_sum/out_err : result beat (adder -> consumer)
// modport master : producer/consumer side (drives operands and out_ready)
// modport slave  : the adder itself
interface approx_adder_pipe_et_if #(
  parameter int WIDTH = 8
);
  import approx_adder_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  mode_t            in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
  logic [WIDTH:0]   out_err;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_sum, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_sum, out_err
  );
endinterface

// File: rtl/approx_adder_pipe_et_core.sv
// Combinational approximate/exact adder.
//   a, b   : unsigned operands (WIDTH bits)
//   mode   : exact / LOA / truncate / reserved(=exact)
//   approx : result for the selected mode (WIDTH+1 bits)
//   exact  : true sum a+b (WIDTH+1 bits)
module approx_add_core
  import approx_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LSBS  = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  mode_t            mode,
  output logic [WIDTH:0]   approx,
  output logic [WIDTH:0]   exact
);

  assign exact = {1'b0, a} + {1'b0, b};

  if (LSBS == 0) begin : g_no_approx
    // Nothing to approximate: every mode is exact.
    assign approx = exact;
  end else begin : g_approx
    localparam int UW = WIDTH - LSBS;  // width of the exact upper part

    logic [LSBS-1:0] lo_or;
    logic            carry_est;
    logic [UW:0]     up_loa;
    logic [UW:0]     up_trunc;

    assign lo_or     = a[LSBS-1:0] | b[LSBS-1:0];
    // LOA guesses the carry out of the lower part from its top bit pair.
    assign carry_est = a[LSBS-1] & b[LSBS-1];

    if (UW == 0) begin : g_all_low
      // Every bit is approximated; only the estimated carry reaches the MSB.
      assign up_loa   = carry_est;
      assign up_trunc = '0;
    end else begin : g_split
      assign up_loa   = {1'b0, a[WIDTH-1:LSBS]} + {1'b0, b[WIDTH-1:LSBS]}
                      + {{UW{1'b0}}, carry_est};
      assign up_trunc = {1'b0, a[WIDTH-1:LSBS]} + {1'b0, b[WIDTH-1:LSBS]};
    end

    always_comb begin
      approx = exact;
      case (mode)
        MODE_LOA:   approx = {up_loa, lo_or};
        MODE_TRUNC: approx = {up_trunc, {LSBS{1'b0}}};
        default:    approx = exact;
      endcase
    end
  end

endmodule

// File: rtl/approx_adder_pipe_et.sv
// Two-stage pipelined approximate adder with error-threshold monitor.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : operand/result streams (slave modport)
//   stat_clr  : synchronous clear of err_max / viol_cnt / et_viol
//   err_max   : largest out_err transferred since reset/clear
//   viol_cnt  : saturating count of transferred results with out_err > ET
//   et_viol   : sticky flag, any violation since reset/clear
// S1 registers the operands and mode; the core sits between S1 and S2, so
// S2 holds the finished sum and its error against the exact result.
module approx_adder_pipe_et
  import approx_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LSBS  = 3,
  parameter int ET    = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  approx_adder_pipe_et_if.slave  bus,
  input  logic                   stat_clr,
  output logic [WIDTH:0]         err_max,
  output logic [CNT_W-1:0]       viol_cnt,
  output logic                   et_viol
);

  if (WIDTH < 2 || LSBS < 0 || LSBS > WIDTH || CNT_W < 1 || ET < 0 ||
      WIDTH + 1 > ABS_W) begin : g_param_err
    $error("approx_adder_pipe_et: illegal parameter combination");
  end

  localparam logic [ABS_W-1:0] ET_W = ABS_W'(ET);

  logic             s1_v_q, s1_v_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  mode_t            s1_mode_q, s1_mode_d;
  logic             s2_v_q, s2_v_d;
  logic [WIDTH:0]   s2_sum_q, s2_sum_d, s2_err_q, s2_err_d;
  logic [WIDTH:0]   err_max_q, err_max_d;
  logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;
  logic             et_viol_q, et_viol_d;

  logic             s2_adv;
  logic             in_ready_w;
  logic             out_xfer;
  logic [WIDTH:0]   approx_w, exact_w, err_w;

  approx_add_core #(.WIDTH(WIDTH), .LSBS(LSBS)) u_core (
    .a      (s1_a_q),
    .b      (s1_b_q),
    .mode   (s1_mode_q),
    .approx (approx_w),
    .exact  (exact_w)
  );

  assign err_w = (WIDTH+1)'(abs_diff(ABS_W'(exact_w), ABS_W'(approx_w)));

  // S2 may take a new beat when empty or when its current beat leaves;
  // S1 may take one when empty or when its beat moves on into S2.
  assign s2_adv     = !s2_v_q || bus.out_ready;
  assign in_ready_w = !s1_v_q || s2_adv;
  assign out_xfer   = s2_v_q && bus.out_ready;

  always_comb begin
    s1_v_d     = s1_v_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_mode_d  = s1_mode_q;
    s2_v_d     = s2_v_q;
    s2_sum_d   = s2_sum_q;
    s2_err_d   = s2_err_q;
    err_max_d  = err_max_q;
    viol_cnt_d = viol_cnt_q;
    et_viol_d  = et_viol_q;

    if (in_ready_w) begin
      s1_v_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_a_d    = bus.in_a;
        s1_b_d    = bus.in_b;
        s1_mode_d = bus.in_mode;
      end
    end

    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_sum_d = approx_w;
        s2_err_d = err_w;
      end
    end

    // Clear wins over a simultaneous transfer, which is then not recorded.
    if (stat_clr) begin
      err_max_d  = '0;
      viol_cnt_d = '0;
      et_viol_d  = 1'b0;
    end else if (out_xfer) begin
      if (s2_err_q > err_max_q) err_max_d = s2_err_q;
      if (ABS_W'(s2_err_q) > ET_W) begin
        et_viol_d = 1'b1;
        if (viol_cnt_q != '1) viol_cnt_d = viol_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_mode_q  <= MODE_EXACT;
      s2_v_q     <= 1'b0;
      s2_sum_q   <= '0;
      s2_err_q   <= '0;
      err_max_q  <= '0;
      viol_cnt_q <= '0;
      et_viol_q  <= 1'b0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_mode_q  <= s1_mode_d;
      s2_v_q     <= s2_v_d;
      s2_sum_q   <= s2_sum_d;
      s2_err_q   <= s2_err_d;
      err_max_q  <= err_max_d;
      viol_cnt_q <= viol_cnt_d;
      et_viol_q  <= et_viol_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = s2_v_q;
  assign bus.out_sum   = s2_sum_q;
  assign bus.out_err   = s2_err_q;
  assign err_max       = err_max_q;
  assign viol_cnt      = viol_cnt_q;
  assign et_viol       = et_viol_q;

endmodule

// File: tb/tb_approx_adder_pipe_et.sv
// Testbench for approx_adder_pipe_et (WIDTH=8, LSBS=3, ET=4, CNT_W=2 so the
// saturating counter is exercised). A negedge monitor keeps an expected-result
// queue and a statistics model computed from plain arithmetic.
module tb_approx_adder_pipe_et;
  import approx_adder_pkg::*;

  localparam int W       = 8;
  localparam int L       = 3;
  localparam int ETH     = 4;
  localparam int CW      = 2;
  localparam int CNT_MAX = 3;

  typedef struct {
    logic [W:0] sum;
    logic [W:0] err;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   m;
    logic [W:0]   sum;
    logic [W:0]   err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          stat_clr;
  logic [W:0]    err_max;
  logic [CW-1:0] viol_cnt;
  logic          et_viol;

  int vec_n  = 0;
  int miss_n = 0;

  exp_t q[$];
  int   m_max, m_cnt, m_et;
  vec_t tbl[9];

  always #5 clk = ~clk;

  approx_adder_pipe_et_if #(.WIDTH(W)) bus ();

  approx_adder_pipe_et #(.WIDTH(W), .LSBS(L), .ET(ETH), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .stat_clr (stat_clr),
    .err_max  (err_max),
    .viol_cnt (viol_cnt),
    .et_viol  (et_viol)
  );

  // Reference: arithmetic straight from the mode definitions (L=3 -> 8 per upper unit).
  function automatic exp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [1:0] m);
    exp_t r;
    int ea, eb, ex, ap;
    ea = int'(a);
    eb = int'(b);
    ex = ea + eb;
    case (m)
      2'd1:    ap = ((ea >> 3) + (eb >> 3) + ((ea >> 2) & (eb >> 2) & 1)) * 8 + ((ea | eb) & 7);
      2'd2:    ap = ((ea >> 3) + (eb >> 3)) * 8;
      default: ap = ex;
    endcase
    r.sum = 9'(ap);
    r.err = 9'((ex >= ap) ? ex - ap : ap - ex);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: sampled at negedge; inputs only change at posedge+1, so the
  // values seen here are the ones the next posedge acts on.
  always @(negedge clk) begin : mon
    if (rst) begin
      q.delete();
      m_max = 0;
      m_cnt = 0;
      m_et  = 0;
    end else begin
      chk("stat_err_max", 32'(err_max), 32'(m_max));
      chk("stat_viol_cnt", 32'(viol_cnt), 32'(m_cnt));
      chk("stat_et_viol", 32'(et_viol), 32'(m_et));
      if (bus.out_valid) begin
        chk("out_has_expected", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          chk("out_sum", 32'(bus.out_sum), 32'(q[0].sum));
          chk("out_err", 32'(bus.out_err), 32'(q[0].err));
          if (bus.out_ready) begin
            if (!stat_clr) begin
              if (int'(q[0].err) > m_max) m_max = int'(q[0].err);
              if (int'(q[0].err) > ETH) begin
                m_et = 1;
                if (m_cnt < CNT_MAX) m_cnt++;
              end
            end
            void'(q.pop_front());
          end
        end
      end
      if (stat_clr) begin
        m_max = 0;
        m_cnt = 0;
        m_et  = 0;
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back(ref_model(bus.in_a, bus.in_b, 2'(bus.in_mode)));
    end
  end

  task automatic set_in(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m);
    bus.in_a    = a;
    bus.in_b    = b;
    bus.in_mode = mode_t'(m);
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m);
    int n;
    n = 0;
    set_in(a, b, m);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("push_accept", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    stat_clr      = 1'b0;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(q.size()), 0);
  endtask

  // One beat into an idle pipe with out_ready=1: checks latency and the table values.
  task automatic apply_vec(input vec_t v, input string nm);
    int n;
    chk({nm, "_in_ready"}, 32'(bus.in_ready), 1);
    set_in(v.a, v.b, v.m);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 10) begin
      tick();
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 2);
    chk({nm, "_sum"}, 32'(bus.out_sum), 32'(v.sum));
    chk({nm, "_err"}, 32'(bus.out_err), 32'(v.err));
    $display("vec %s a=%02h b=%02h mode=%0d sum=%03h err=%0d", nm, v.a, v.b, v.m,
             bus.out_sum, bus.out_err);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int n;
    tbl[0] = '{8'h07, 8'h01, 2'd1, 9'h007, 9'd1};
    tbl[1] = '{8'h07, 8'h07, 2'd2, 9'h000, 9'd14};
    tbl[2] = '{8'hFF, 8'hFF, 2'd0, 9'h1FE, 9'd0};
    tbl[3] = '{8'hFF, 8'hFF, 2'd3, 9'h1FE, 9'd0};
    tbl[4] = '{8'hFF, 8'hFF, 2'd1, 9'h1FF, 9'd1};
    tbl[5] = '{8'hFF, 8'h01, 2'd2, 9'h0F8, 9'd8};
    tbl[6] = '{8'h04, 8'h04, 2'd1, 9'h00C, 9'd4};
    tbl[7] = '{8'h05, 8'h00, 2'd2, 9'h000, 9'd5};
    tbl[8] = '{8'h80, 8'h80, 2'd1, 9'h100, 9'd0};

    rst           = 1'b1;
    stat_clr      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_in('0, '0, 2'd0);
    repeat (3) tick();
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_err_max", 32'(err_max), 0);
    chk("rst_viol_cnt", 32'(viol_cnt), 0);
    chk("rst_et_viol", 32'(et_viol), 0);
    rst = 1'b0;
    tick();

    // Directed table
    for (int i = 0; i < 9; i++) begin
      apply_vec(tbl[i], $sformatf("tbl%0d", i));
      if (i == 0) begin
        chk("t1_err_max", 32'(err_max), 1);
        chk("t1_et_viol", 32'(et_viol), 0);
      end
      if (i == 1) begin
        chk("t2_err_max", 32'(err_max), 14);
        chk("t2_viol_cnt", 32'(viol_cnt), 1);
        chk("t2_et_viol", 32'(et_viol), 1);
      end
    end

    // Backpressure: two beats fit, then in_ready drops
    bus.out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      case (k)
        0: set_in(8'h11, 8'h22, 2'd0);
        1: set_in(8'h3C, 8'h0F, 2'd1);
        2: set_in(8'hA5, 8'h5A, 2'd2);
        default: set_in(8'h7E, 8'h81, 2'd1);
      endcase
      bus.in_valid = 1'b1;
      n = int'(bus.in_ready);
      tick();
      k += n;
    end
    bus.in_valid = 1'b0;
    chk("bp_accepted", 32'(k), 2);
    chk("bp_in_ready", 32'(bus.in_ready), 0);
    chk("bp_out_valid", 32'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    #1;
    push(8'hA5, 8'h5A, 2'd2);
    push(8'h7E, 8'h81, 2'd1);
    drain();
    $display("backpressure: 4 beats drained in order");

    // Saturation and stat_clr on a transfer cycle
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h07, 8'h07, 2'd2);
    drain();
    chk("sat_viol_cnt", 32'(viol_cnt), 3);
    chk("sat_et_viol", 32'(et_viol), 1);
    chk("sat_err_max", 32'(err_max), 14);
    bus.out_ready = 1'b0;
    push(8'h07, 8'h07, 2'd2);
    n = 0;
    while (!bus.out_valid && n < 10) begin
      tick();
      n++;
    end
    chk("clr_out_valid", 32'(bus.out_valid), 1);
    stat_clr      = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("clr_err_max", 32'(err_max), 0);
    chk("clr_viol_cnt", 32'(viol_cnt), 0);
    chk("clr_et_viol", 32'(et_viol), 0);
    chk("clr_out_valid_after", 32'(bus.out_valid), 0);
    $display("saturation/clear sequence done");

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      set_in(W'($urandom), W'($urandom), 2'($urandom_range(0, 3)));
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      stat_clr      = ($urandom_range(0, 19) == 0);
      tick();
    end
    drain();
    $display("random traffic done");

    // Async reset with both stages full
    push(8'h07, 8'h07, 2'd2);
    drain();
    bus.out_ready = 1'b0;
    push(8'h01, 8'h02, 2'd0);
    push(8'h03, 8'h04, 2'd1);
    chk("full_in_ready", 32'(bus.in_ready), 0);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 0);
    chk("arst_err_max", 32'(err_max), 0);
    chk("arst_viol_cnt", 32'(viol_cnt), 0);
    chk("arst_et_viol", 32'(et_viol), 0);
    tick();
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    apply_vec(tbl[0], "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

endmodule
